conv_tap_accumulator: RTL

- Parametrised successor of the stage-3 serial adder in the convolution datapath.
- Sits between the stage-2 multiplier array and the output/pixel-writeback stage.
- Serially accumulates TAPS signed kernel products, one per accepted cycle, in strict tap order.
- Produces a full-precision sum with a valid/ready output handshake, abort support and back-to-back window processing.

---
 rtl/conv_tap_accumulator.sv | 118 +++++++++++
 1 files changed

// File: rtl/conv_tap_accumulator.sv
// Serial signed accumulator for one convolution window of TAPS kernel products.
// Latency: out_valid rises one cycle after the last tap is accepted; stalls extend it.
// Backpressure: result held in DONE until out_ready; optional macro CONV_ACC_RELU_EN clamps negative results to zero.
module conv_tap_accumulator #(
  parameter int IN_W  = 14,
  parameter int TAPS  = 9,
  parameter int ACC_W = IN_W + $clog2(TAPS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [TAPS*IN_W-1:0]         prod,
  input  logic [TAPS-1:0]              prod_valid,
  output logic signed [ACC_W-1:0]      out_sum,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic [$clog2(TAPS)-1:0]      tap_idx
);

  localparam int TAP_W = $clog2(TAPS);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state;
  logic signed [ACC_W-1:0] acc;

  logic [IN_W-1:0]         prod_arr [TAPS];
  logic [IN_W-1:0]         cur_prod;
  logic                    cur_valid;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] final_sum;

  // Split the packed product bus into per-tap lanes
  for (genvar k = 0; k < TAPS; k++) begin : g_unpack
    assign prod_arr[k] = prod[k*IN_W +: IN_W];
  end

  // Select the awaited tap and form the sign-extended running sum
  always_comb begin
    cur_prod  = prod_arr[tap_idx];
    cur_valid = prod_valid[tap_idx];
    acc_next  = acc + {{(ACC_W-IN_W){cur_prod[IN_W-1]}}, cur_prod};
`ifdef CONV_ACC_RELU_EN
    final_sum = acc_next[ACC_W-1] ? '0 : acc_next;
`else
    final_sum = acc_next;
`endif
  end

  // Window FSM: all outputs are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      tap_idx   <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // abort beats start so a simultaneous request is dropped
          if (start && !abort) begin
            state   <= ACCUM;
            acc     <= '0;
            tap_idx <= '0;
            busy    <= 1'b1;
          end
        end
        ACCUM: begin
          if (abort) begin
            state   <= IDLE;
            acc     <= '0;
            tap_idx <= '0;
            busy    <= 1'b0;
          end else if (cur_valid) begin
            acc <= acc_next;
            if (tap_idx == LAST_TAP) begin
              state     <= DONE;
              tap_idx   <= '0;
              out_sum   <= final_sum;
              out_valid <= 1'b1;
            end else begin
              tap_idx <= tap_idx + TAP_W'(1);
            end
          end
        end
        DONE: begin
          // abort is deliberately ignored: a finished result is never lost
          if (out_ready) begin
            out_valid <= 1'b0;
            if (start) begin
              state   <= ACCUM;
              acc     <= '0;
              tap_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
